// File: rtl/text_layer.sv
// text_layer: character-cell text renderer with a writable screen buffer, blink attribute
// and a hardware clear engine; 3-cycle pixel pipeline feeding an external font ROM.
module text_layer #(
  parameter int COLS       = 40,
  parameter int ROWS       = 30,
  parameter int GLYPH_W    = 8,
  parameter int GLYPH_H    = 8,
  parameter int SCALE_LOG2 = 1,
  parameter int CHAR_BITS  = 7,
  parameter int COLOR_BITS = 4,
  parameter int X_BITS     = 10,
  parameter int Y_BITS     = 10,
  parameter int ORIGIN_X   = 0,
  parameter int ORIGIN_Y   = 0,
  parameter int BLINK_LOG2 = 5,
  parameter int ADDR_W     = $clog2(COLS*ROWS),
  parameter int GA_W       = CHAR_BITS + $clog2(GLYPH_H)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [CHAR_BITS-1:0]  wr_char,
  input  logic [COLOR_BITS-1:0] wr_fg,
  input  logic [COLOR_BITS-1:0] wr_bg,
  input  logic                  wr_blink,
  input  logic                  clr_start,
  input  logic [COLOR_BITS-1:0] clr_fg,
  input  logic [COLOR_BITS-1:0] clr_bg,
  output logic                  clr_busy,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  input  logic [X_BITS-1:0]     pix_x,
  input  logic [Y_BITS-1:0]     pix_y,
  output logic [GA_W-1:0]       glyph_addr,
  input  logic [GLYPH_W-1:0]    glyph_row,
  output logic                  out_valid,
  output logic                  out_on,
  output logic [COLOR_BITS-1:0] out_color
);
  localparam int N = COLS*ROWS;
  localparam int GW_L2 = $clog2(GLYPH_W);
  localparam int GH_L2 = $clog2(GLYPH_H);
  localparam int CW = 1 + 2*COLOR_BITS + CHAR_BITS;
  localparam int WIN_W = (COLS*GLYPH_W) << SCALE_LOG2;
  localparam int WIN_H = (ROWS*GLYPH_H) << SCALE_LOG2;
  localparam logic [CHAR_BITS-1:0] SPACE = CHAR_BITS'(32'h20);

  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, wa, rd_addr;
  logic [COLOR_BITS-1:0] cfg_q, cfg_d, cbg_q, cbg_d;
  logic [CW-1:0] mem [N];
  logic [CW-1:0] cell_q, wd;
  logic we;
  logic [BLINK_LOG2:0] frame_q, frame_d;
  logic [X_BITS:0] dx;
  logic [Y_BITS:0] dy;
  logic [31:0] col, row;
  logic on0;
  logic v1_q, v1_d, on1_q, on1_d, v2_q, v2_d, on2_q, on2_d, blank2_q, blank2_d;
  logic [GW_L2-1:0] gx1_q, gx1_d, gx2_q, gx2_d;
  logic [GH_L2-1:0] gy1_q, gy1_d;
  logic [COLOR_BITS-1:0] fg2_q, fg2_d, bg2_q, bg2_d;
  logic out_valid_q, out_valid_d, out_on_q, out_on_d;
  logic [COLOR_BITS-1:0] out_color_q, out_color_d;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && clr_start) state_d = CLEAR;
    else if (state_q == CLEAR && cnt_q == ADDR_W'(N-1)) state_d = IDLE;
    cnt_d = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
    cfg_d = (state_q == IDLE && clr_start) ? clr_fg : cfg_q;
    cbg_d = (state_q == IDLE && clr_start) ? clr_bg : cbg_q;
  end

  // The clear engine owns the write port while busy; user writes are dropped
  always_comb begin
    clr_busy = state_q == CLEAR;
    we = clr_busy || (wr_en && 32'(wr_addr) < N);
    wa = clr_busy ? cnt_q : wr_addr;
    wd = clr_busy ? {1'b0, cbg_q, cfg_q, SPACE} : {wr_blink, wr_bg, wr_fg, wr_char};
  end

  // Synchronous read: a same-cycle write to the read address returns the old word
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    cell_q <= mem[rd_addr];
  end

  always_comb begin
    dx = {1'b0, pix_x} - (X_BITS+1)'(ORIGIN_X);
    dy = {1'b0, pix_y} - (Y_BITS+1)'(ORIGIN_Y);
    on0 = pix_valid && !dx[X_BITS] && !dy[Y_BITS] && 32'(dx) < WIN_W && 32'(dy) < WIN_H;
    col = 32'(dx) >> (SCALE_LOG2 + GW_L2);
    row = 32'(dy) >> (SCALE_LOG2 + GH_L2);
    rd_addr = on0 ? ADDR_W'(row*COLS + col) : '0;
    frame_d = frame_start ? frame_q + 1'b1 : frame_q;
    v1_d = pix_valid;
    on1_d = on0;
    gx1_d = GW_L2'(dx >> SCALE_LOG2);
    gy1_d = GH_L2'(dy >> SCALE_LOG2);
    glyph_addr = on1_q ? {cell_q[CHAR_BITS-1:0], gy1_q} : '0;
    v2_d = v1_q;
    on2_d = on1_q;
    gx2_d = gx1_q;
    fg2_d = cell_q[CHAR_BITS +: COLOR_BITS];
    bg2_d = cell_q[CHAR_BITS+COLOR_BITS +: COLOR_BITS];
    blank2_d = cell_q[CW-1] && frame_q[BLINK_LOG2];
    out_valid_d = v2_q;
    out_on_d = on2_q;
    out_color_d = !on2_q ? '0 : (glyph_row[gx2_q] && !blank2_q) ? fg2_q : bg2_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      cfg_q <= '0;
      cbg_q <= '0;
      frame_q <= '0;
      v1_q <= 1'b0;
      on1_q <= 1'b0;
      gx1_q <= '0;
      gy1_q <= '0;
      v2_q <= 1'b0;
      on2_q <= 1'b0;
      gx2_q <= '0;
      fg2_q <= '0;
      bg2_q <= '0;
      blank2_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_on_q <= 1'b0;
      out_color_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cfg_q <= cfg_d;
      cbg_q <= cbg_d;
      frame_q <= frame_d;
      v1_q <= v1_d;
      on1_q <= on1_d;
      gx1_q <= gx1_d;
      gy1_q <= gy1_d;
      v2_q <= v2_d;
      on2_q <= on2_d;
      gx2_q <= gx2_d;
      fg2_q <= fg2_d;
      bg2_q <= bg2_d;
      blank2_q <= blank2_d;
      out_valid_q <= out_valid_d;
      out_on_q <= out_on_d;
      out_color_q <= out_color_d;
    end

  assign out_valid = out_valid_q;
  assign out_on = out_on_q;
  assign out_color = out_color_q;
endmodule
